pwm_sequencer: RTL and testbench
================================

Name: pwm_sequencer

Overview:
- Start/stop/fault controller for the three-phase sine PWM datapath.
- Generates the three 8-bit phase angles (U, V, W at 120° spacing) that feed the sine-PWM lookup stages, plus an amplitude scale and gate-enable controls.
- Bootstrap precharge, frequency ramp-up/ramp-down and fault shutdown are sequenced by one FSM.
- Sits between the system control logic and the sine-PWM/PWM stages; runs on the system clock and replaces the free-running divided-clock angle counters.

Parameters:
- PRESC, 64, system-clock cycles per update tick (>=2).
- RAMP_STEP, 16'd64, freq_word change per tick during ramps.
- PRECHG_TICKS, 1000, ticks spent in precharge (>=1).
- VF_SHIFT, 4, right shift applied to freq_word to form amp (V/f law).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request run; level-sampled in IDLE
- stop  in  1  request controlled stop; level
- fault  in  1  external fault, level, highest priority
- fault_clr  in  1  leave FAULT; honoured only while fault=0
- freq_target  in  16  target phase-accumulator increment; latched on leaving IDLE
- theta_u  out  8  U angle
- theta_v  out  8  V angle
- theta_w  out  8  W angle
- amp  out  8  amplitude scale for duty
- gate_en  out  1  high-side/low-side PWM outputs permitted
- low_force  out  1  force all low-side switches on (bootstrap precharge)
- state  out  3  current FSM state (debug)

Behaviour:
- Single clock domain. All outputs are registered, so every output reflects the state/registers one clk after the causing edge.
- Reset (synchronous, active-high):
  - state=IDLE; prescaler=0; acc=0; freq_word=0; tgt=0.
  - All outputs 0, except theta_v=85 and theta_w=171.
- Tick generation:
  - Prescaler counts 0..PRESC-1. tick=1 in the cycle the count equals PRESC-1, then it wraps to 0.
  - The prescaler free-runs in all states and is cleared only by rst.
- Angle generation:
  - acc is 16 bits. On each tick in RAMP_UP, RUN or RAMP_DN: acc <= acc + freq_word (mod 2^16).
  - theta_u = acc[15:8]; theta_v = theta_u + 85 (mod 256); theta_w = theta_u + 171 (mod 256).
- Amplitude: amp = min(255, freq_word >> VF_SHIFT) in RAMP_UP/RUN/RAMP_DN; otherwise 0.
- States (encoding in package): IDLE=0, PRECHG=1, RAMP_UP=2, RUN=3, RAMP_DN=4, FAULT=5.
  - IDLE:
    - If start=1 and stop=0: latch tgt <= freq_target, clear the precharge tick counter, go to PRECHG.
    - start and stop both high: stay IDLE.
    - acc=0 and freq_word=0 while in IDLE.
  - PRECHG:
    - low_force=1, gate_en=0.
    - After PRECHG_TICKS ticks, go to RAMP_UP.
    - stop=1: go to IDLE immediately (next clk).
  - RAMP_UP:
    - Each tick: freq_word <= min(freq_word + RAMP_STEP, tgt), 17-bit intermediate, no overflow.
    - When freq_word==tgt, go to RUN. tgt=0 reaches RUN on the first tick.
    - stop=1: go to RAMP_DN.
  - RUN: freq_word held; stop=1 goes to RAMP_DN.
  - RAMP_DN:
    - Each tick: freq_word <= (freq_word > RAMP_STEP) ? freq_word - RAMP_STEP : 0.
    - When freq_word==0: go to IDLE and clear acc.
    - start is ignored in RAMP_DN.
  - FAULT:
    - Entered from any state in the clk after fault=1, including mid-ramp.
    - On entry: gate_en=0, low_force=0, freq_word=0, acc held.
    - Exit to IDLE when fault_clr=1 and fault=0. A fault_clr while fault=1 is ignored.
- Priority: rst > fault > stop > start.
- gate_en=1 only in RAMP_UP/RUN/RAMP_DN. gate_en and low_force are never both 1.

Optional Feature:
- PWM_SEQ_DIR_REV_EN: adds input port dir (1 bit), latched with tgt on leaving IDLE.
  - dir=1: theta_v = theta_u + 171 and theta_w = theta_u + 85 (reverse phase order).
  - dir=0: forward order as above.
- Macro undefined: no dir port, forward order only.

Decomposition:
- Package pwm_seq_pkg holds:
  - the state enum and its 3-bit encoding;
  - phase-offset constants PH_120=8'd85 and PH_240=8'd171;
  - the angle/amplitude widths.
- One natural sub-module, pwm_seq_tick: the PRESC prescaler emitting tick.
- FSM, ramp and accumulator stay in the top block.

Test Plan (PRESC=4, RAMP_STEP=256, PRECHG_TICKS=2, VF_SHIFT=4):
- Reset, then idle 20 clk -> all outputs 0 except theta_v=85 and theta_w=171; state=0.
- start pulse with freq_target=1024 -> low_force=1 for 2 ticks (8 clk); then RAMP_UP with freq_word 256, 512, 768, 1024 on successive ticks; state=RUN; amp=64; theta_u advances 4 per tick; theta_v-theta_u=85 throughout.
- stop in RUN -> RAMP_DN with freq_word 768, 512, 256, 0; then IDLE with acc=0; gate_en falls with the IDLE entry.
- fault mid-RAMP_UP -> next clk state=FAULT and gate_en=0; fault_clr while fault=1 stays in FAULT; fault_clr after fault drops -> IDLE.
- start and stop high together in IDLE -> remains IDLE. stop during PRECHG -> IDLE next clk, low_force=0.
- freq_target=300 -> ramp 256 then 300 (clamped), RUN; with PWM_SEQ_DIR_REV_EN and dir=1 -> theta_v-theta_u=171.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the three-phase PWM start/stop/fault sequencer.
package pwm_seq_pkg;

    localparam int ANG_W = 8;
    localparam int AMP_W = 8;
    localparam int ACC_W = 16;
    localparam int ST_W  = 3;

    localparam logic [ANG_W-1:0] PH_120 = 8'd85;
    localparam logic [ANG_W-1:0] PH_240 = 8'd171;

    typedef enum logic [ST_W-1:0] {
        S_IDLE    = 3'd0,
        S_PRECHG  = 3'd1,
        S_RAMP_UP = 3'd2,
        S_RUN     = 3'd3,
        S_RAMP_DN = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    // V/f amplitude: shifted frequency word, saturated to the amplitude width
    function automatic logic [AMP_W-1:0] amp_sat(input logic [ACC_W-1:0] fw,
                                                 input int unsigned       sh);
        logic [ACC_W-1:0] s;
        s = fw >> sh;
        return (s > 16'd255) ? 8'hFF : s[AMP_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_seq_tick.sv
// Free-running update-tick prescaler; tick is high during the last count of each period.
module pwm_seq_tick #(
    parameter int PRESC = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);
    localparam int CW = (PRESC > 2) ? $clog2(PRESC) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(PRESC - 1));
    assign o_tick = w_last;

    always_ff @(posedge i_clk) begin
        if (i_rst)       r_cnt <= '0;
        else if (w_last) r_cnt <= '0;
        else             r_cnt <= r_cnt + CW'(1);
    end

endmodule

// File: rtl/pwm_sequencer.sv
// Precharge / ramp / run / fault sequencer producing three-phase angles and V/f amplitude.
// Optional reverse phase order: define PWM_SEQ_DIR_REV_EN to add the i_dir input.
module pwm_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int          PRESC        = 64,
    parameter logic [15:0] RAMP_STEP    = 16'd64,
    parameter int          PRECHG_TICKS = 1000,
    parameter int          VF_SHIFT     = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_fault,
    input  logic             i_fault_clr,
    input  logic [15:0]      i_freq_target,
`ifdef PWM_SEQ_DIR_REV_EN
    input  logic             i_dir,
`endif
    output logic [ANG_W-1:0] o_theta_u,
    output logic [ANG_W-1:0] o_theta_v,
    output logic [ANG_W-1:0] o_theta_w,
    output logic [AMP_W-1:0] o_amp,
    output logic             o_gate_en,
    output logic             o_low_force,
    output logic [ST_W-1:0]  o_state
);
    localparam int PC_W = $clog2(PRECHG_TICKS + 1);

    state_t           r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [ACC_W-1:0] r_fw, w_fw_nxt;
    logic [ACC_W-1:0] r_tgt, w_tgt_nxt;
    logic [PC_W-1:0]  r_pc, w_pc_nxt;
    logic             w_tick;
    logic [ACC_W:0]   w_fw_up;
    logic [ACC_W-1:0] w_fw_clip;
    logic [ACC_W-1:0] w_fw_dn;
    logic             w_run_nxt;
    logic [ANG_W-1:0] w_th_u;
    logic [ANG_W-1:0] w_ofs_v;
    logic [ANG_W-1:0] w_ofs_w;

    pwm_seq_tick #(.PRESC(PRESC)) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    // Ramp arithmetic in 17 bits so a target near 0xFFFF never wraps
    assign w_fw_up   = {1'b0, r_fw} + {1'b0, RAMP_STEP};
    assign w_fw_clip = (w_fw_up > {1'b0, r_tgt}) ? r_tgt : w_fw_up[ACC_W-1:0];
    assign w_fw_dn   = (r_fw > RAMP_STEP) ? (r_fw - RAMP_STEP) : '0;

`ifdef PWM_SEQ_DIR_REV_EN
    logic r_dir, w_dir_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_fw_nxt    = r_fw;
        w_tgt_nxt   = r_tgt;
        w_pc_nxt    = r_pc;
`ifdef PWM_SEQ_DIR_REV_EN
        w_dir_nxt   = r_dir;
`endif
        if (w_tick && (r_state == S_RAMP_UP || r_state == S_RUN || r_state == S_RAMP_DN))
            w_acc_nxt = r_acc + r_fw;

        if (i_fault) begin
            w_state_nxt = S_FAULT;
            w_fw_nxt    = '0;
            w_acc_nxt   = r_acc;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_acc_nxt = '0;
                    w_fw_nxt  = '0;
                    if (i_start && !i_stop) begin
                        w_tgt_nxt   = i_freq_target;
                        w_pc_nxt    = '0;
                        w_state_nxt = S_PRECHG;
`ifdef PWM_SEQ_DIR_REV_EN
                        w_dir_nxt   = i_dir;
`endif
                    end
                end
                S_PRECHG: begin
                    if (i_stop) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_tick) begin
                        if (r_pc == PC_W'(PRECHG_TICKS - 1)) w_state_nxt = S_RAMP_UP;
                        else                                 w_pc_nxt    = r_pc + PC_W'(1);
                    end
                end
                S_RAMP_UP: begin
                    if (i_stop) begin
                        w_state_nxt = S_RAMP_DN;
                    end else if (w_tick) begin
                        w_fw_nxt = w_fw_clip;
                        if (w_fw_clip == r_tgt) w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_stop) w_state_nxt = S_RAMP_DN;
                end
                S_RAMP_DN: begin
                    if (w_tick) begin
                        w_fw_nxt = w_fw_dn;
                        if (w_fw_dn == '0) begin
                            w_state_nxt = S_IDLE;
                            w_acc_nxt   = '0;
                        end
                    end
                end
                S_FAULT: begin
                    if (i_fault_clr) begin
                        w_state_nxt = S_IDLE;
                        w_acc_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_acc_nxt   = '0;
                    w_fw_nxt    = '0;
                end
            endcase
        end
    end

    assign w_run_nxt = (w_state_nxt == S_RAMP_UP) || (w_state_nxt == S_RUN) ||
                       (w_state_nxt == S_RAMP_DN);
    assign w_th_u    = w_acc_nxt[ACC_W-1:ACC_W-ANG_W];

`ifdef PWM_SEQ_DIR_REV_EN
    assign w_ofs_v = w_dir_nxt ? PH_240 : PH_120;
    assign w_ofs_w = w_dir_nxt ? PH_120 : PH_240;
`else
    assign w_ofs_v = PH_120;
    assign w_ofs_w = PH_240;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_fw    <= '0;
            r_tgt   <= '0;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_fw    <= w_fw_nxt;
            r_tgt   <= w_tgt_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

`ifdef PWM_SEQ_DIR_REV_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) r_dir <= 1'b0;
        else       r_dir <= w_dir_nxt;
    end
`endif

    // Outputs are registered from next-state values so they line up with o_state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_theta_u   <= '0;
            o_theta_v   <= PH_120;
            o_theta_w   <= PH_240;
            o_amp       <= '0;
            o_gate_en   <= 1'b0;
            o_low_force <= 1'b0;
            o_state     <= S_IDLE;
        end else begin
            o_theta_u   <= w_th_u;
            o_theta_v   <= w_th_u + w_ofs_v;
            o_theta_w   <= w_th_u + w_ofs_w;
            o_amp       <= w_run_nxt ? amp_sat(w_fw_nxt, VF_SHIFT) : '0;
            o_gate_en   <= w_run_nxt;
            o_low_force <= (w_state_nxt == S_PRECHG);
            o_state     <= w_state_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer: precharge timing, ramps, run, stop, fault and clamping.
module tb_pwm_sequencer;
    localparam int          PRESC        = 4;
    localparam logic [15:0] RAMP_STEP    = 16'd256;
    localparam int          PRECHG_TICKS = 2;
    localparam int          VF_SHIFT     = 4;
`ifdef PWM_SEQ_DIR_REV_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, fault = 1'b0, fault_clr = 1'b0;
    logic [15:0] freq_target = '0;
    logic [7:0]  theta_u, theta_v, theta_w, amp;
    logic        gate_en, low_force;
    logic [2:0]  state;
`ifdef PWM_SEQ_DIR_REV_EN
    logic        dir = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;
    int tb_cnt = 0;

    always #5 clk = ~clk;

    pwm_sequencer #(
        .PRESC(PRESC), .RAMP_STEP(RAMP_STEP),
        .PRECHG_TICKS(PRECHG_TICKS), .VF_SHIFT(VF_SHIFT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
        .i_fault(fault), .i_fault_clr(fault_clr), .i_freq_target(freq_target),
`ifdef PWM_SEQ_DIR_REV_EN
        .i_dir(dir),
`endif
        .o_theta_u(theta_u), .o_theta_v(theta_v), .o_theta_w(theta_w),
        .o_amp(amp), .o_gate_en(gate_en), .o_low_force(low_force), .o_state(state)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock; mirrors the prescaler count so tick edges are known in advance
    task automatic step();
        @(posedge clk);
        if (rst) tb_cnt = 0;
        else     tb_cnt = (tb_cnt == PRESC - 1) ? 0 : tb_cnt + 1;
        #1;
    endtask

    task automatic step_tick();
        int pre;
        for (int i = 0; i < PRESC; i++) begin
            pre = tb_cnt;
            step();
            if (pre == PRESC - 1) return;
        end
        chk("tick_timeout", 0, 1);
    endtask

    task automatic wait_state(input int st);
        for (int i = 0; i < 40; i++) begin
            if (state == 3'(st)) return;
            step();
        end
        chk("wait_state_timeout", state, st);
    endtask

    task automatic expo(input string tag, input int st, input int tu, input int a,
                        input int ge, input int lf, input bit rev);
        chk({tag, ".state"}, state, st);
        chk({tag, ".theta_u"}, theta_u, tu);
        chk({tag, ".theta_v"}, theta_v, (tu + (rev ? 171 : 85)) % 256);
        chk({tag, ".theta_w"}, theta_w, (tu + (rev ? 85 : 171)) % 256);
        chk({tag, ".amp"}, amp, a);
        chk({tag, ".gate_en"}, gate_en, ge);
        chk({tag, ".low_force"}, low_force, lf);
    endtask

    initial begin
        int lf_cnt;
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();
        expo("reset", 0, 0, 0, 0, 0, 1'b0);

        // start aligned so the first PRECHG clock follows a tick edge
        for (int i = 0; i < PRESC && tb_cnt != PRESC - 1; i++) step();
        freq_target = 16'd1024;
        start = 1'b1;
        step();
        start = 1'b0;
        lf_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (low_force) lf_cnt++;
            step();
        end
        chk("prechg_len", lf_cnt, 8);
        expo("up_entry", 2, 0, 0, 1, 0, 1'b0);
        step_tick(); expo("up1", 2, 0, 16, 1, 0, 1'b0);
        step_tick(); expo("up2", 2, 1, 32, 1, 0, 1'b0);
        step_tick(); expo("up3", 2, 3, 48, 1, 0, 1'b0);
        step_tick(); expo("run1", 3, 6, 64, 1, 0, 1'b0);
        step_tick(); expo("run2", 3, 10, 64, 1, 0, 1'b0);
        step_tick(); expo("run3", 3, 14, 64, 1, 0, 1'b0);

        stop = 1'b1;
        step();      expo("dn_entry", 4, 14, 64, 1, 0, 1'b0);
        step_tick(); expo("dn1", 4, 18, 48, 1, 0, 1'b0);
        step_tick(); expo("dn2", 4, 21, 32, 1, 0, 1'b0);
        step_tick(); expo("dn3", 4, 23, 16, 1, 0, 1'b0);
        step_tick(); expo("dn_idle", 0, 0, 0, 0, 0, 1'b0);
        stop = 1'b0;
        step();

        // fault mid ramp-up, clear ignored while fault is high
        start = 1'b1;
        step();
        start = 1'b0;
        wait_state(2);
        step_tick(); expo("f_up1", 2, 0, 16, 1, 0, 1'b0);
        step_tick(); expo("f_up2", 2, 1, 32, 1, 0, 1'b0);
        fault = 1'b1;
        step();      expo("fault", 5, 1, 0, 0, 0, 1'b0);
        fault_clr = 1'b1;
        repeat (6) step();
        expo("fault_hold", 5, 1, 0, 0, 0, 1'b0);
        fault = 1'b0;
        step();      expo("fault_exit", 0, 0, 0, 0, 0, 1'b0);
        fault_clr = 1'b0;

        start = 1'b1; stop = 1'b1;
        repeat (5) step();
        expo("start_stop", 0, 0, 0, 0, 0, 1'b0);
        stop = 1'b0;
        step();      expo("pc_in", 1, 0, 0, 0, 1, 1'b0);
        start = 1'b0; stop = 1'b1;
        step();      expo("pc_stop", 0, 0, 0, 0, 0, 1'b0);
        stop = 1'b0;

        // zero target reaches RUN on the first ramp tick
        freq_target = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_state(2);
        step_tick(); expo("z_run", 3, 0, 0, 1, 0, 1'b0);
        stop = 1'b1;
        step();      expo("z_dn", 4, 0, 0, 1, 0, 1'b0);
        step_tick(); expo("z_idle", 0, 0, 0, 0, 0, 1'b0);
        stop = 1'b0;
        step();

        // clamped ramp, optional reverse order, fault beats stop
        freq_target = 16'd300;
`ifdef PWM_SEQ_DIR_REV_EN
        dir = 1'b1;
`endif
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef PWM_SEQ_DIR_REV_EN
        dir = 1'b0;
`endif
        wait_state(2);
        step_tick(); expo("c_up", 2, 0, 16, 1, 0, REV);
        step_tick(); expo("c_run", 3, 1, 18, 1, 0, REV);
        step_tick(); expo("c_run2", 3, 2, 18, 1, 0, REV);
        stop = 1'b1; fault = 1'b1;
        step();      expo("prio", 5, 2, 0, 0, 0, REV);
        stop = 1'b0; fault = 1'b0; fault_clr = 1'b1;
        step();
        chk("final_idle", state, 0);
        fault_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
